// File: rtl/gray_xs3_decoder_if.sv
// Handshake bundle for the Gray / excess-3 decoder: an input word channel and a
// decoded-result channel. The decoder uses the slave view; its driver uses the master view.
interface gray_xs3_decoder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/gray_xs3_decoder.sv
// Iterative decoder: Gray -> binary one bit per cycle (MSB first) or
// excess-3 -> BCD one nibble per cycle (MS nibble first), with valid/ready on both sides.
module gray_xs3_decoder #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  gray_xs3_decoder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] GRAY_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] XS3_LAST  = CW'(WIDTH / 4 - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic             run_bit;
  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;

  logic             accept;
  logic             last_step;
  logic             gray_bit;
  logic [3:0]       nibble;
  logic             nibble_bad;
  logic [3:0]       digit;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == BUSY) && (cnt == '0);

  // The step counter doubles as the bit index (Gray) or nibble index (excess-3).
  assign gray_bit   = data_q[cnt] ^ run_bit;
  assign nibble     = data_q[{cnt, 2'b00} +: 4];
  assign nibble_bad = (nibble < 4'd3) || (nibble > 4'd12);
  assign digit      = nibble_bad ? 4'hF : (nibble - 4'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // run_bit carries b[i+1] into the next Gray step; it starts at 0 so b[MSB] = g[MSB].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      run_bit    <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else if (accept) begin
      data_q    <= bus.in_data;
      mode_q    <= bus.in_mode;
      cnt       <= bus.in_mode ? XS3_LAST : GRAY_LAST;
      run_bit   <= 1'b0;
      out_err_q <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (!mode_q) begin
        out_data_q[cnt] <= gray_bit;
        run_bit         <= gray_bit;
      end else begin
        out_data_q[{cnt, 2'b00} +: 4] <= digit;
        if (nibble_bad) out_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_gray_xs3_decoder.sv
// Directed bench for gray_xs3_decoder: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
module tb_gray_xs3_decoder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  gray_xs3_decoder_if #(.WIDTH(4)) bus4 ();
  gray_xs3_decoder_if #(.WIDTH(8)) bus8 ();

  gray_xs3_decoder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  gray_xs3_decoder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outData(input bit wide);
    return wide ? 32'(bus8.out_data) : 32'(bus4.out_data);
  endfunction

  function automatic logic outValid(input bit wide);
    return wide ? bus8.out_valid : bus4.out_valid;
  endfunction

  function automatic logic outErr(input bit wide);
    return wide ? bus8.out_err : bus4.out_err;
  endfunction

  function automatic logic inReady(input bit wide);
    return wide ? bus8.in_ready : bus4.in_ready;
  endfunction

  // Offer one word, count edges until the result appears, check it, then drain it.
  task automatic applyStimulus(input string tag, input bit wide, input logic [7:0] data,
                               input logic mode, input logic [7:0] exp_data,
                               input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(inReady(wide)), 32'd1);
    if (wide) begin
      bus8.in_valid = 1'b1; bus8.in_data = data; bus8.in_mode = mode;
    end else begin
      bus4.in_valid = 1'b1; bus4.in_data = data[3:0]; bus4.in_mode = mode;
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!outValid(wide) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_data"}, outData(wide), 32'(exp_data));
    checkOutput({tag, "_err"}, 32'(outErr(wide)), 32'(exp_err));
    bus4.out_ready = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    bus8.out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, 32'(outValid(wide)), 32'd0);
    checkOutput({tag, "_drain_ready"}, 32'(inReady(wide)), 32'd1);
  endtask

  logic [3:0] gray_inv [16];

  initial begin
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = 1'b0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_mode = 1'b0; bus8.out_ready = 1'b0;
    // Binary value for each Gray code index, from g = b ^ (b >> 1).
    gray_inv = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                 4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

    #12;
    checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus4.out_data), 32'd0);
    checkOutput("rst_out_err", 32'(bus4.out_err), 32'd0);
    checkOutput("rst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("rst8_in_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("gray_1000", 1'b0, 8'h08, 1'b0, 8'h0F, 1'b0, 4);
    for (int g = 0; g < 16; g++) begin
      applyStimulus($sformatf("gray_sweep_%0d", g), 1'b0, 8'(g), 1'b0, 8'(gray_inv[g]), 1'b0, 4);
    end

    applyStimulus("xs3_3C", 1'b1, 8'h3C, 1'b1, 8'h09, 1'b0, 2);
    applyStimulus("xs3_2A", 1'b1, 8'h2A, 1'b1, 8'hF7, 1'b1, 2);
    applyStimulus("xs3_C3", 1'b1, 8'hC3, 1'b1, 8'h90, 1'b0, 2);
    applyStimulus("xs3_0F", 1'b1, 8'h0F, 1'b1, 8'hFF, 1'b1, 2);
    applyStimulus("xs3_5B", 1'b1, 8'h5B, 1'b1, 8'h28, 1'b0, 2);
    applyStimulus("gray8_FF", 1'b1, 8'hFF, 1'b0, 8'hAA, 1'b0, 8);
    applyStimulus("xs3w4_7", 1'b0, 8'h07, 1'b1, 8'h04, 1'b0, 1);
    applyStimulus("xs3w4_D", 1'b0, 8'h0D, 1'b1, 8'h0F, 1'b1, 1);

    // Backpressure: result held in DONE while a competing word is offered.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_data = 8'h47; bus8.in_mode = 1'b1;
    @(posedge clk); #1;
    bus8.in_data = 8'h3C;
    bus8.in_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("bp_valid_start", 32'(bus8.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_valid_%0d", c), 32'(bus8.out_valid), 32'd1);
      checkOutput($sformatf("bp_data_%0d", c), 32'(bus8.out_data), 32'h14);
      checkOutput($sformatf("bp_in_ready_%0d", c), 32'(bus8.in_ready), 32'd0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    checkOutput("bp_release_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_no_accept_busy", 32'(bus8.busy), 32'd0);
    checkOutput("bp_data_kept", 32'(bus8.out_data), 32'h14);

    // Asynchronous reset in the middle of a Gray decode.
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.in_data = 4'b1000; bus4.in_mode = 1'b0;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_busy", 32'(bus4.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(bus4.out_data), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst_1101", 1'b0, 8'h0D, 1'b0, 8'h09, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
